// File: rtl/registradores_pkg.sv
// Shared sizing and encoding constants for the register-file write arbiter.
package registradores_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);
    localparam int DATA_W     = 32;

    localparam logic                  REQ_ALU  = 1'b0;
    localparam logic                  REQ_MEM  = 1'b1;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/arbitro_rr2.sv
// Two-input round-robin grant (ALU vs. load) with the "last winner" flop.
module arbitro_rr2
    import registradores_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic req_alu,
    input  logic req_mem,
    output logic gnt_alu,
    output logic gnt_mem,
    output logic ultimo
);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        gnt_alu = 1'b0;
        gnt_mem = 1'b0;
        if (reset_n) begin
            if (req_alu && req_mem) begin
                gnt_mem = (ultimo == REQ_ALU);
                gnt_alu = (ultimo == REQ_MEM);
            end else begin
                gnt_alu = req_alu;
                gnt_mem = req_mem;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ultimo <= REQ_ALU;
        end else if (gnt_alu) begin
            ultimo <= REQ_ALU;
        end else if (gnt_mem) begin
            ultimo <= REQ_MEM;
        end
    end

endmodule

// File: rtl/arbitro_escrita_reg.sv
// Register-file write-port arbiter with pending-write scoreboard and hazard detect.
// Optional macro ARBITRO_FORWARDING_EN forwards the in-flight write to the read ports.
module arbitro_escrita_reg
    import registradores_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0]     alu_dados,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0]     mem_dados,
    output logic                  mem_ready,
    input  logic                  reserva_valid,
    input  logic [REG_ADDR_W-1:0] reserva_reg,
    input  logic [REG_ADDR_W-1:0] regLe1,
    input  logic [REG_ADDR_W-1:0] regLe2,
    input  logic [DATA_W-1:0]     dadosLe1_rf,
    input  logic [DATA_W-1:0]     dadosLe2_rf,
    output logic [DATA_W-1:0]     dadosLe1,
    output logic [DATA_W-1:0]     dadosLe2,
    output logic                  perigo,
    output logic                  escReg,
    output logic [REG_ADDR_W-1:0] regEsc,
    output logic [DATA_W-1:0]     dadosEsc
);

    logic                  gnt_alu;
    logic                  gnt_mem;
    logic                  ultimo;
    logic                  gnt_any;
    logic [REG_ADDR_W-1:0] win_reg;
    logic [DATA_W-1:0]     win_dados;
    logic [NUM_REGS-1:0]   busy;
    logic                  fwd1;
    logic                  fwd2;

    arbitro_rr2 u_rr (
        .clock   (clock),
        .reset_n (reset_n),
        .req_alu (alu_valid),
        .req_mem (mem_valid),
        .gnt_alu (gnt_alu),
        .gnt_mem (gnt_mem),
        .ultimo  (ultimo)
    );

    assign alu_ready = gnt_alu;
    assign mem_ready = gnt_mem;
    assign gnt_any   = gnt_alu | gnt_mem;
    assign win_reg   = gnt_mem ? mem_reg   : alu_reg;
    assign win_dados = gnt_mem ? mem_dados : alu_dados;

    // A grant to register 0 still completes the handshake but never enables the write.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            escReg   <= 1'b0;
            regEsc   <= REG_ZERO;
            dadosEsc <= '0;
        end else begin
            escReg <= gnt_any && (win_reg != REG_ZERO);
            if (gnt_any) begin
                regEsc   <= win_reg;
                dadosEsc <= win_dados;
            end
        end
    end

    // NOTE: the busy bits are control state, so unlike a data RAM they must be reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (reserva_valid && reserva_reg == REG_ADDR_W'(r)) begin
                    busy[r] <= 1'b1;
                end else if (escReg && regEsc == REG_ADDR_W'(r)) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

`ifdef ARBITRO_FORWARDING_EN
    assign fwd1 = escReg && (regEsc == regLe1) && (regLe1 != REG_ZERO);
    assign fwd2 = escReg && (regEsc == regLe2) && (regLe2 != REG_ZERO);
    assign dadosLe1 = fwd1 ? dadosEsc : dadosLe1_rf;
    assign dadosLe2 = fwd2 ? dadosEsc : dadosLe2_rf;
`else
    assign fwd1     = 1'b0;
    assign fwd2     = 1'b0;
    assign dadosLe1 = dadosLe1_rf;
    assign dadosLe2 = dadosLe2_rf;
`endif

    // A read that is being satisfied by forwarding does not need to stall.
    assign perigo = (busy[regLe1] && (regLe1 != REG_ZERO) && !fwd1) ||
                    (busy[regLe2] && (regLe2 != REG_ZERO) && !fwd2);

endmodule
